// File: rtl/ones_density_pkg.sv
// Shared constants and types for the ones-density measurement framer.
// Holds the frame sync byte, the flag bit layout and the transmit FSM states.
package ones_density_pkg;

  localparam logic [7:0] SYNC_BYTE    = 8'h53;
  localparam int         FLAG_OVR_BIT = 7;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    ACK,
    DRAIN
  } tx_state_e;

  // FLAGS byte: only the overrun bit is defined, every other bit reads as zero.
  function automatic logic [7:0] flags_byte(input logic ovr);
    logic [7:0] f;
    f = '0;
    f[FLAG_OVR_BIT] = ovr;
    return f;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous pad input.
// Output is the second-stage flop; reset clears both stages.
module bit_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ones_density_framer.sv
// Counts synchronized comparator ones over a 2^WIN_LOG2 clock window and sends
// each accepted result as a checksummed byte frame through a busy/start UART handshake.
module ones_density_framer
  import ones_density_pkg::*;
#(
  parameter int WIN_LOG2  = 24,
  parameter int CNT_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              comp_in,
  input  logic              en,
  input  logic              tx_busy,
  output logic [7:0]        tx_dat,
  output logic              tx_start,
  output logic [WIN_LOG2:0] sample,
  output logic              sample_valid,
  output logic              overrun
);

  localparam int CNT_W = 8 * CNT_BYTES;
  localparam int IDX_W = $clog2(CNT_BYTES + 3);
  localparam logic [IDX_W-1:0] SYNC_IDX  = '0;
  localparam logic [IDX_W-1:0] FLAGS_IDX = IDX_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(CNT_BYTES + 2);

  if (WIN_LOG2 < 4 || WIN_LOG2 > 30) begin : g_win_range_err
    $error("ones_density_framer: WIN_LOG2 must be within 4..30");
  end
  if (CNT_W < WIN_LOG2 + 1) begin : g_cnt_bytes_err
    $error("ones_density_framer: CNT_BYTES too small to hold WIN_LOG2+1 count bits");
  end

  logic s;

  bit_sync u_comp_sync (
    .clk (clk),
    .rst (rst),
    .d_i (comp_in),
    .q_o (s)
  );

  // ---------------- window accumulation ----------------
  logic [WIN_LOG2-1:0] win_ctr_q;
  logic [WIN_LOG2:0]   ones_q;
  logic [WIN_LOG2:0]   ones_sum;
  logic [WIN_LOG2:0]   sample_q;
  logic                sample_valid_q;
  logic                win_end;

  // The extra count bit lets an all-ones window read 2^WIN_LOG2 instead of wrapping.
  assign ones_sum = ones_q + {{WIN_LOG2{1'b0}}, s};
  assign win_end  = en && (&win_ctr_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      win_ctr_q      <= '0;
      ones_q         <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      sample_valid_q <= win_end;
      if (en) begin
        win_ctr_q <= win_ctr_q + WIN_LOG2'(1);
        ones_q    <= win_end ? '0 : ones_sum;
      end
      if (win_end) begin
        sample_q <= ones_sum;
      end
    end
  end

  // ---------------- frame transmitter ----------------
  tx_state_e        state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       chk_q, chk_d;
  logic [CNT_W-1:0] cnt_sh_q, cnt_sh_d;
  logic [7:0]       flags_q, flags_d;
  logic             sticky_q, sticky_d;
  logic [7:0]       tx_dat_q, tx_dat_d;
  logic             tx_start_q, tx_start_d;
  logic             overrun_q, overrun_d;
  logic [CNT_W-1:0] sample_ext;
  logic [7:0]       byte_sel;
  logic             is_cnt_byte;

  always_comb begin
    sample_ext = '0;
    sample_ext[WIN_LOG2:0] = ones_sum;
  end

  // Count bytes leave MSB first from the top of a shift register, avoiding a wide mux.
  always_comb begin
    is_cnt_byte = 1'b0;
    if (idx_q == SYNC_IDX) begin
      byte_sel = SYNC_BYTE;
    end else if (idx_q == FLAGS_IDX) begin
      byte_sel = flags_q;
    end else if (idx_q == LAST_IDX) begin
      byte_sel = chk_q;
    end else begin
      byte_sel    = cnt_sh_q[CNT_W-1 -: 8];
      is_cnt_byte = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    chk_d      = chk_q;
    cnt_sh_d   = cnt_sh_q;
    flags_d    = flags_q;
    sticky_d   = sticky_q;
    tx_dat_d   = tx_dat_q;
    tx_start_d = 1'b0;
    overrun_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (win_end) begin
          cnt_sh_d = sample_ext;
          flags_d  = flags_byte(sticky_q);
          sticky_d = 1'b0;
          idx_d    = '0;
          chk_d    = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          tx_dat_d   = byte_sel;
          tx_start_d = 1'b1;
          chk_d      = chk_q ^ byte_sel;
          if (is_cnt_byte) begin
            cnt_sh_d = cnt_sh_q << 8;
          end
          state_d = ACK;
        end
      end
      ACK: begin
        if (tx_busy) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!tx_busy) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Any window finishing outside IDLE (including the DRAIN->IDLE cycle) is dropped.
    if (win_end && state_q != IDLE) begin
      overrun_d = 1'b1;
      sticky_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      chk_q      <= '0;
      cnt_sh_q   <= '0;
      flags_q    <= '0;
      sticky_q   <= 1'b0;
      tx_dat_q   <= '0;
      tx_start_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      chk_q      <= chk_d;
      cnt_sh_q   <= cnt_sh_d;
      flags_q    <= flags_d;
      sticky_q   <= sticky_d;
      tx_dat_q   <= tx_dat_d;
      tx_start_q <= tx_start_d;
      overrun_q  <= overrun_d;
    end
  end

  assign tx_dat       = tx_dat_q;
  assign tx_start     = tx_start_q;
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_ones_density_framer.sv
// Directed bench for ones_density_framer with a 16-clock window and a simple
// UART busy model; prints one line per received frame plus a summary.
module tb_ones_density_framer;

  localparam int WIN_LOG2  = 4;
  localparam int CNT_BYTES = 4;
  localparam int FRAME_LEN = CNT_BYTES + 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              comp_in;
  logic              en;
  logic              tx_busy;
  logic [7:0]        tx_dat;
  logic              tx_start;
  logic [WIN_LOG2:0] sample;
  logic              sample_valid;
  logic              overrun;

  int checks   = 0;
  int failures = 0;

  int cyc       = 0;
  int t0        = 0;
  int uart_hold = 20;
  int comp_mode = 0;

  logic [7:0] got [$];
  int         ovr_count = 0;
  int         sv_count  = 0;
  int         prot_viol = 0;
  logic       prev_start = 1'b0;
  logic [7:0] exp_f [FRAME_LEN];

  ones_density_framer #(
    .WIN_LOG2  (WIN_LOG2),
    .CNT_BYTES (CNT_BYTES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .comp_in      (comp_in),
    .en           (en),
    .tx_busy      (tx_busy),
    .tx_dat       (tx_dat),
    .tx_start     (tx_start),
    .sample       (sample),
    .sample_valid (sample_valid),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // comp_in pattern generator: 0 = low, 1 = high, 2 = toggle every clock
  initial begin
    comp_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (comp_mode)
        0:       comp_in = 1'b0;
        1:       comp_in = 1'b1;
        default: comp_in = ~comp_in;
      endcase
    end
  end

  // UART model: busy rises 1 clock after tx_start and stays high uart_hold clocks
  initial begin
    int  busy_left;
    bit  start_seen;
    busy_left  = 0;
    start_seen = 1'b0;
    tx_busy    = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) tx_busy = 1'b0;
      end
      if (start_seen) begin
        tx_busy    = 1'b1;
        busy_left  = uart_hold;
        start_seen = 1'b0;
      end
      if (tx_start) start_seen = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (tx_start) begin
      got.push_back(tx_dat);
      if (tx_busy || prev_start) prot_viol <= prot_viol + 1;
    end
    if (overrun)      ovr_count <= ovr_count + 1;
    if (sample_valid) sv_count  <= sv_count + 1;
    prev_start <= tx_start;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    en  = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_sv(input int limit, output int delta, output bit ok);
    ok    = 1'b0;
    delta = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (sample_valid) begin
        ok    = 1'b1;
        delta = cyc - t0;
        break;
      end
    end
  endtask

  task automatic wait_bytes(input int base, input int n, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      step();
      if (got.size() >= base + n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // One full window from win_ctr=0 with en dropped right after it, timing captured.
  task automatic run_window(input int mode, output int sv_delta, output int st_delta,
                            output logic [WIN_LOG2:0] smp);
    bit ok;
    comp_mode = mode;
    repeat (3) step();
    t0 = cyc;
    en = 1'b1;
    repeat (16) step();
    en = 1'b0;
    wait_sv(50, sv_delta, ok);
    smp      = sample;
    st_delta = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_start) begin
        st_delta = cyc - t0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int sv0;
    rst = 1'b1;
    en = 1'b0;
    comp_mode = 0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (tx_start !== 1'b0)     begin failures++; $display("FAIL reset_tx_start: got %b expected 0", tx_start); end
    checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL reset_sample_valid: got %b expected 0", sample_valid); end
    checks++; if (overrun !== 1'b0)      begin failures++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    checks++; if (tx_dat !== 8'h00)      begin failures++; $display("FAIL reset_tx_dat: got %02h expected 00", tx_dat); end
    checks++; if (sample !== 5'd0)       begin failures++; $display("FAIL reset_sample: got %0d expected 0", sample); end
    comp_mode = 1;
    step();
    sv0 = sv_count;
    repeat (40) step();
    checks++; if (sv_count !== sv0) begin failures++; $display("FAIL en_low_hold: got %0d windows expected 0", sv_count - sv0); end
  endtask

  task automatic test_window(input string name, input int mode, input logic [7:0] val,
                             input logic [7:0] chk);
    int sv_d, st_d, base, ov0;
    logic [WIN_LOG2:0] smp;
    bit ok;
    do_reset();
    uart_hold = 20;
    base = got.size();
    ov0  = ovr_count;
    run_window(mode, sv_d, st_d, smp);
    checks++; if (sv_d !== 16)       begin failures++; $display("FAIL %s sv_latency: got %0d expected 16", name, sv_d); end
    checks++; if (st_d !== 17)       begin failures++; $display("FAIL %s start_latency: got %0d expected 17", name, st_d); end
    checks++; if (smp !== val[4:0])  begin failures++; $display("FAIL %s sample: got %0d expected %0d", name, smp, val); end
    exp_f = '{8'h53, 8'h00, 8'h00, 8'h00, 8'h00, val, chk};
    wait_bytes(base, FRAME_LEN, 400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL %s frame_timeout: got %0d bytes expected %0d", name, got.size() - base, FRAME_LEN); end
    if (ok) begin
      for (int i = 0; i < FRAME_LEN; i++) begin
        checks++;
        if (got[base+i] !== exp_f[i]) begin
          failures++;
          $display("FAIL %s byte%0d: got %02h expected %02h", name, i, got[base+i], exp_f[i]);
        end
      end
      $display("frame %s: sample=%0d chk=%02h", name, smp, got[base+FRAME_LEN-1]);
    end
    repeat (40) step();
    checks++; if (ovr_count !== ov0) begin failures++; $display("FAIL %s no_overrun: got %0d pulses expected 0", name, ovr_count - ov0); end
  endtask

  task automatic test_overrun();
    int base, ov0, ov1, sv_d;
    bit ok;
    do_reset();
    uart_hold = 200;
    base = got.size();
    ov0  = ovr_count;
    comp_mode = 1;
    repeat (3) step();
    en = 1'b1;
    wait_bytes(base, FRAME_LEN, 3000, ok);
    en = 1'b0;
    checks++; if (!ok) begin failures++; $display("FAIL ovr_frame1_timeout: got %0d bytes expected %0d", got.size() - base, FRAME_LEN); end
    checks++; if (!(ovr_count > ov0)) begin failures++; $display("FAIL ovr_pulsed: got %0d pulses expected >0", ovr_count - ov0); end
    exp_f = '{8'h53, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h43};
    if (ok) begin
      for (int i = 0; i < FRAME_LEN; i++) begin
        checks++;
        if (got[base+i] !== exp_f[i]) begin failures++; $display("FAIL ovr_frame1 byte%0d: got %02h expected %02h", i, got[base+i], exp_f[i]); end
      end
      $display("frame ovr1: flags=%02h", got[base+1]);
    end
    repeat (260) step();

    uart_hold = 20;
    base = got.size();
    ov1  = ovr_count;
    t0   = cyc;
    en   = 1'b1;
    wait_sv(40, sv_d, ok);
    step();
    en = 1'b0;
    checks++; if (sample !== 5'd16) begin failures++; $display("FAIL ovr_frame2_sample: got %0d expected 16", sample); end
    exp_f = '{8'h53, 8'h80, 8'h00, 8'h00, 8'h00, 8'h10, 8'hC3};
    wait_bytes(base, FRAME_LEN, 400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL ovr_frame2_timeout: got %0d bytes expected %0d", got.size() - base, FRAME_LEN); end
    if (ok) begin
      for (int i = 0; i < FRAME_LEN; i++) begin
        checks++;
        if (got[base+i] !== exp_f[i]) begin failures++; $display("FAIL ovr_frame2 byte%0d: got %02h expected %02h", i, got[base+i], exp_f[i]); end
      end
      $display("frame ovr2: flags=%02h", got[base+1]);
    end
    repeat (40) step();
    checks++; if (ovr_count !== ov1) begin failures++; $display("FAIL ovr_frame2_clean: got %0d pulses expected 0", ovr_count - ov1); end

    base = got.size();
    en   = 1'b1;
    wait_sv(40, sv_d, ok);
    step();
    en = 1'b0;
    exp_f = '{8'h53, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h43};
    wait_bytes(base, FRAME_LEN, 400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL ovr_frame3_timeout: got %0d bytes expected %0d", got.size() - base, FRAME_LEN); end
    if (ok) begin
      for (int i = 0; i < FRAME_LEN; i++) begin
        checks++;
        if (got[base+i] !== exp_f[i]) begin failures++; $display("FAIL ovr_frame3 byte%0d: got %02h expected %02h", i, got[base+i], exp_f[i]); end
      end
      $display("frame ovr3: flags=%02h", got[base+1]);
    end
    repeat (40) step();
  endtask

  task automatic test_en_gap();
    int base, sv_d;
    bit ok;
    do_reset();
    uart_hold = 20;
    comp_mode = 1;
    repeat (3) step();
    base = got.size();
    t0 = cyc;
    en = 1'b1;
    repeat (5) step();
    en = 1'b0;
    repeat (10) step();
    en = 1'b1;
    wait_sv(60, sv_d, ok);
    step();
    en = 1'b0;
    checks++; if (sv_d !== 26)      begin failures++; $display("FAIL en_gap_latency: got %0d expected 26", sv_d); end
    checks++; if (sample !== 5'd16) begin failures++; $display("FAIL en_gap_sample: got %0d expected 16", sample); end
    wait_bytes(base, FRAME_LEN, 400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL en_gap_frame_timeout: got %0d bytes expected %0d", got.size() - base, FRAME_LEN); end
    $display("frame en_gap: sample=%0d", sample);
    repeat (40) step();
  endtask

  task automatic test_reset_mid_frame();
    int base, b2;
    bit ok;
    do_reset();
    uart_hold = 20;
    comp_mode = 1;
    repeat (3) step();
    base = got.size();
    en = 1'b1;
    repeat (16) step();
    en = 1'b0;
    wait_bytes(base, 3, 300, ok);
    checks++; if (!ok) begin failures++; $display("FAIL midrst_3_starts: got %0d bytes expected 3", got.size() - base); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL midrst_tx_start: got %b expected 0", tx_start); end
    checks++; if (tx_dat !== 8'h00)  begin failures++; $display("FAIL midrst_tx_dat: got %02h expected 00", tx_dat); end
    checks++; if (sample !== 5'd0)   begin failures++; $display("FAIL midrst_sample: got %0d expected 0", sample); end
    b2 = got.size();
    repeat (300) step();
    checks++; if (got.size() !== b2) begin failures++; $display("FAIL midrst_abandon: got %0d extra starts expected 0", got.size() - b2); end
    en = 1'b1;
    repeat (16) step();
    en = 1'b0;
    exp_f = '{8'h53, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h43};
    wait_bytes(b2, FRAME_LEN, 400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL midrst_frame_timeout: got %0d bytes expected %0d", got.size() - b2, FRAME_LEN); end
    if (ok) begin
      for (int i = 0; i < FRAME_LEN; i++) begin
        checks++;
        if (got[b2+i] !== exp_f[i]) begin failures++; $display("FAIL midrst_frame byte%0d: got %02h expected %02h", i, got[b2+i], exp_f[i]); end
      end
      $display("frame after_reset: chk=%02h", got[b2+FRAME_LEN-1]);
    end
    repeat (40) step();
  endtask

  task automatic test_protocol();
    step();
    checks++; if (prot_viol !== 0) begin failures++; $display("FAIL protocol: got %0d violations expected 0", prot_viol); end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    test_reset();
    test_window("all_ones", 1, 8'h10, 8'h43);
    test_window("toggle",   2, 8'h08, 8'h5B);
    test_window("all_zero", 0, 8'h00, 8'h53);
    test_overrun();
    test_en_gap();
    test_reset_mid_frame();
    test_protocol();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
